script_stack_ctrl: RTL
======================

// Module: script_stack_ctrl
// PURPOSE
//  Main-stack owner and ALU operand feeder for the script engine; drives the AluScript operand side, absorbs its result side.
//  Parser feeds data pushes and opcodes. Block pops operands into ALU, holds them until done, pushes results back.
//  It streams extra elements for OP_CHECKMULTISIG on pop_req. At script end it reports pass/fail.
// PARAMETERS
//  WIDTH    512   stack element width, bits
//  DEPTH    16    max stack entries
//  TIMEOUT  4096  max cycles waiting for ALU done before fault
// PORTS
//  clk            in   1      clock
//  rst            in   1      async active-high reset
//  sclear         in   1      sync clear: empty stack, clear fault, go IDLE
//  push_valid     in   1      parser data push request
//  push_data      in   WIDTH  element to push
//  push_ready     out  1      push accepted when valid&ready
//  op_valid       in   1      parser opcode request
//  opcode         in   8      opcode
//  op_ready       out  1      opcode accepted when valid&ready
//  script_end     in   1      parser finished script (sampled in IDLE)
//  alu_opcode     out  8      opcode held to ALU during EXEC/MSIG
//  put_alu_in1    out  1      operand 1 valid
//  data_alu_in1   out  WIDTH  operand 1 (former top of stack)
//  put_alu_in2    out  1      operand 2 valid
//  data_alu_in2   out  WIDTH  operand 2 (former second entry)
//  put_alu_out1   in   1      ALU result 1 push
//  data_alu_out1  in   WIDTH  ALU result 1
//  put_alu_out2   in   1      ALU result 2 push
//  data_alu_out2  in   WIDTH  ALU result 2
//  pop_req        in   1      ALU requests next element (multisig)
//  done           in   1      ALU op complete
//  error          in   1      ALU op failed (valid with done)
//  stack_depth    out  $clog2(DEPTH+1)  current entry count
//  result_valid   out  1      1-cycle pulse: script verdict
//  result_pass    out  1      verdict, valid with result_valid
//  fault          out  1      sticky fault level
//  fault_code     out  3      1 underflow,2 overflow,3 alu error,4 timeout,5 illegal op
// BEHAVIOUR
//  Reset: all outputs 0, sp=0, state IDLE. Reset mid-op aborts immediately. No ALU strobe after rst.
//  States: IDLE, EXEC, MSIG, FAULT. push_ready=op_ready=0 outside IDLE. In IDLE push beats op: op_ready=!push_valid.
//  Push: accept writes push_data at sp and sets sp+1. sp==DEPTH at accept -> FAULT code 2, data dropped.
//  Op accept (cycle T): n = operand count from package table:
//    OP_0, OP_2..OP_16 n=0; OP_DUP, OP_HASH160 n=1; OP_EQUAL, OP_EQUALVERIFY, OP_CHECKSIG n=2; OP_CHECKMULTISIG n=1.
//    Unknown opcode -> FAULT code 5. sp<n -> FAULT code 1. Either way the opcode is consumed.
//    Otherwise capture top to in1 and second to in2 (registered), sp-=n. Go to EXEC, or MSIG for CHECKMULTISIG.
//  EXEC from T+1: alu_opcode, put_alu_in1=(n>=1), put_alu_in2=(n==2) held constant until done sampled.
//  On done: error -> FAULT code 3. Else push out1 at sp if put_alu_out1, then out2 above it if put_alu_out2, in one edge.
//    Overflow at that push -> FAULT code 2. Next state IDLE. Min op latency 2 cycles.
//  MSIG: put_alu_in1=1. On each cycle pop_req=1, load the new top (after pop) into in1 and set sp-=1.
//    pop_req with sp==0 -> FAULT code 1. done/error are handled as in EXEC.
//  Timeout counter resets on entry to EXEC/MSIG. Reaching TIMEOUT without done -> FAULT code 4.
//  done and pop_req in the same cycle: done wins, pop is ignored.
//  script_end in IDLE: result_valid=1 for 1 cycle, result_pass=(sp!=0)&&(top!=0). Stack is then cleared.
//    script_end with push/op valid in the same cycle: end is deferred until the bus is quiet.
//  FAULT: fault=1 and fault_code held, ALU puts deasserted. script_end pulses result_valid with result_pass=0.
//    Exit only by rst or sclear.
//  Widths: sp saturates 0..DEPTH, never wraps. TIMEOUT counter is $clog2(TIMEOUT+1) bits.
// STRUCTURE
//  script_pkg: OP_* localparams (OP_0=8'h00, OP_2..16=8'h52..8'h60, OP_DUP=8'h76, OP_EQUAL=8'h87,
//    OP_EQUALVERIFY=8'h88, OP_HASH160=8'ha9, OP_CHECKSIG=8'hac, OP_CHECKMULTISIG=8'hae).
//  script_pkg also holds the state_t enum, fault_code_t enum and function op_nargs(opcode).
//  Sub-module script_stack_mem: DEPTH x WIDTH regfile with 2 read ports (sp-1, sp-2) and 2 write ports.
// TESTING
//  P2PKH: push sig, pubkey; DUP; HASH160 (done after 5 cycles); push h; EQUALVERIFY; CHECKSIG result 1; end.
//    Required: result_pass=1, stack_depth=1 before end.
//  Underflow: empty stack, OP_EQUAL -> fault=1, fault_code=1, no put_alu_in*. sclear -> fault=0, push_ready=1.
//  Overflow: DEPTH=4, 5 pushes -> 5th causes fault_code=2, stack_depth stays 4.
//  EQUALVERIFY mismatch: ALU done+error -> fault_code=3. script_end then gives result_valid=1, result_pass=0.
//  Multisig: stack {3,k3,k2,k1,2,s2,s1,0}, pop_req 7 times, then done.
//    Required: in1 sequence 3,k3,k2,k1,2,s2,s1,0; result 1 on top; pop_req at sp==0 -> code 1.
//  Timeout: TIMEOUT=8, done never set -> fault_code=4 exactly 8 cycles after EXEC entry.
//  Async rst mid-EXEC -> all outputs 0 at once, stack_depth=0.

Source files
------------

// File: rtl/script_pkg.sv
// Opcode constants, state/fault encodings and operand-count table
// shared by the script engine stack controller.
package script_pkg;

    localparam logic [7:0] OP_0             = 8'h00;
    localparam logic [7:0] OP_2             = 8'h52;
    localparam logic [7:0] OP_16            = 8'h60;
    localparam logic [7:0] OP_DUP           = 8'h76;
    localparam logic [7:0] OP_EQUAL         = 8'h87;
    localparam logic [7:0] OP_EQUALVERIFY   = 8'h88;
    localparam logic [7:0] OP_HASH160       = 8'ha9;
    localparam logic [7:0] OP_CHECKSIG      = 8'hac;
    localparam logic [7:0] OP_CHECKMULTISIG = 8'hae;

    // Operand count of 3 marks an opcode the engine does not implement
    localparam logic [1:0] NARGS_BAD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MSIG,
        S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        F_NONE      = 3'd0,
        F_UNDERFLOW = 3'd1,
        F_OVERFLOW  = 3'd2,
        F_ALU       = 3'd3,
        F_TIMEOUT   = 3'd4,
        F_ILLEGAL   = 3'd5
    } fault_code_t;

    function automatic logic [1:0] op_nargs(input logic [7:0] op);
        logic [1:0] n;
        n = NARGS_BAD;
        case (op) inside
            OP_0, [OP_2:OP_16]:                   n = 2'd0;
            OP_DUP, OP_HASH160, OP_CHECKMULTISIG: n = 2'd1;
            OP_EQUAL, OP_EQUALVERIFY, OP_CHECKSIG: n = 2'd2;
            default:                              n = NARGS_BAD;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/script_stack_mem.sv
// Stack element storage: two asynchronous read ports (top, second)
// and two write ports so an ALU can return two results in one edge.
module script_stack_mem #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/script_stack_ctrl.sv
// Main-stack owner for the script engine: accepts parser pushes/opcodes,
// feeds operands to the ALU, absorbs results and reports the verdict.
module script_stack_ctrl #(
    parameter int WIDTH   = 512,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclear,
    input  logic                         push_valid,
    input  logic [WIDTH-1:0]             push_data,
    output logic                         push_ready,
    input  logic                         op_valid,
    input  logic [7:0]                   opcode,
    output logic                         op_ready,
    input  logic                         script_end,
    output logic [7:0]                   alu_opcode,
    output logic                         put_alu_in1,
    output logic [WIDTH-1:0]             data_alu_in1,
    output logic                         put_alu_in2,
    output logic [WIDTH-1:0]             data_alu_in2,
    input  logic                         put_alu_out1,
    input  logic [WIDTH-1:0]             data_alu_out1,
    input  logic                         put_alu_out2,
    input  logic [WIDTH-1:0]             data_alu_out2,
    input  logic                         pop_req,
    input  logic                         done,
    input  logic                         error,
    output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
    output logic                         result_valid,
    output logic                         result_pass,
    output logic                         fault,
    output logic [2:0]                   fault_code
);

    import script_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           state;
    fault_code_t      cause;
    logic [SW-1:0]    sp, sp_m1, sp_p1;
    logic [SW:0]      sp_res;
    logic [TW-1:0]    tcnt;
    logic [7:0]       op_q;
    logic [WIDTH-1:0] in1_q, in2_q, rd_top, rd_sec, wdata0;
    logic [AW-1:0]    a_wr0, a_wr1, a_top, a_sec;
    logic [1:0]       nargs;
    logic             n1_q, n2_q, idle, busy, full, ovf;
    logic             push_fire, op_fire, we0, we1;

    assign idle  = state == S_IDLE;
    assign busy  = (state == S_EXEC) || (state == S_MSIG);
    assign sp_m1 = sp - SW'(1);
    assign sp_p1 = sp + SW'(1);
    assign sp_res = {1'b0, sp} + (SW+1)'(put_alu_out1) + (SW+1)'(put_alu_out2);
    assign full  = sp == SW'(DEPTH);
    assign ovf   = sp_res > (SW+1)'(DEPTH);
    assign nargs = op_nargs(opcode);

    assign push_ready = idle && !rst;
    assign op_ready   = idle && !rst && !push_valid;
    assign push_fire  = push_valid && push_ready;
    assign op_fire    = op_valid && op_ready;

    assign alu_opcode   = busy ? op_q : '0;
    assign put_alu_in1  = busy && n1_q;
    assign put_alu_in2  = busy && n2_q;
    assign data_alu_in1 = in1_q;
    assign data_alu_in2 = in2_q;
    assign stack_depth  = sp;

    always_comb begin
        cause = F_NONE;
        if (idle) begin
            if (push_fire) begin
                if (full) cause = F_OVERFLOW;
            end else if (op_fire) begin
                if (nargs == NARGS_BAD)    cause = F_ILLEGAL;
                else if (sp < SW'(nargs)) cause = F_UNDERFLOW;
            end
        end else if (busy) begin
            // done outranks both the timeout and a concurrent pop
            if (done) begin
                if (error)    cause = F_ALU;
                else if (ovf) cause = F_OVERFLOW;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
                cause = F_TIMEOUT;
            end else if (state == S_MSIG && pop_req && sp == '0) begin
                cause = F_UNDERFLOW;
            end
        end
    end

    // Port 0 takes a parser push or the lower ALU result, port 1 the upper
    assign wdata0 = push_fire ? push_data :
                    (put_alu_out1 ? data_alu_out1 : data_alu_out2);
    assign we0 = !sclear && cause == F_NONE &&
                 (push_fire || (busy && done && (put_alu_out1 || put_alu_out2)));
    assign we1 = !sclear && cause == F_NONE && busy && done &&
                 put_alu_out1 && put_alu_out2;

    assign a_wr0 = AW'(sp);
    assign a_wr1 = AW'(sp_p1);
    assign a_top = AW'(sp_m1);
    assign a_sec = AW'(sp) - AW'(2);

    script_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (a_wr0),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (a_wr1),
        .wdata1 (data_alu_out2),
        .raddr0 (a_top),
        .rdata0 (rd_top),
        .raddr1 (a_sec),
        .rdata1 (rd_sec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            sp           <= '0;
            tcnt         <= '0;
            op_q         <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            n1_q         <= 1'b0;
            n2_q         <= 1'b0;
            result_valid <= 1'b0;
            result_pass  <= 1'b0;
            fault        <= 1'b0;
            fault_code   <= '0;
        end else begin
            result_valid <= 1'b0;
            if (sclear) begin
                state       <= S_IDLE;
                sp          <= '0;
                fault       <= 1'b0;
                fault_code  <= '0;
                result_pass <= 1'b0;
            end else if (cause != F_NONE) begin
                state      <= S_FAULT;
                fault      <= 1'b1;
                fault_code <= cause;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (push_fire) begin
                            sp <= sp_p1;
                        end else if (op_fire) begin
                            op_q  <= opcode;
                            in1_q <= (nargs != 2'd0) ? rd_top : '0;
                            in2_q <= (nargs == 2'd2) ? rd_sec : '0;
                            n1_q  <= nargs != 2'd0;
                            n2_q  <= nargs == 2'd2;
                            sp    <= sp - SW'(nargs);
                            tcnt  <= '0;
                            state <= (opcode == OP_CHECKMULTISIG) ? S_MSIG : S_EXEC;
                        end else if (script_end) begin
                            result_valid <= 1'b1;
                            result_pass  <= (sp != '0) && (rd_top != '0);
                            sp           <= '0;
                        end
                    end
                    S_EXEC, S_MSIG: begin
                        if (done) begin
                            sp    <= sp_res[SW-1:0];
                            state <= S_IDLE;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                            if (state == S_MSIG && pop_req) begin
                                in1_q <= rd_top;
                                sp    <= sp_m1;
                            end
                        end
                    end
                    S_FAULT: begin
                        if (script_end) begin
                            result_valid <= 1'b1;
                            result_pass  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
